// File: rtl/core_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_defs
//   Shared definitions for the 8085-style machine-cycle sequencer:
//   bus/address widths, chk_inst flag indices, the HLT opcode, the binary
//   state encodings, and the immediate-operand opcode decode.
//   No ports (package).
// ----------------------------------------------------------------------------
package core_defs;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 16;
    localparam int INSTSIZE = 2;

    // chk_inst bit positions driven by the datapath decoder
    localparam int INST_GO6 = 0;
    localparam int INST_DAD = 1;

    localparam logic [7:0] OPC_HLT = 8'h76;

    // Sequencer states, binary encoded
    localparam int STATE_W = 5;
    localparam logic [STATE_W-1:0] ST_T1  = 5'd0;
    localparam logic [STATE_W-1:0] ST_T2  = 5'd1;
    localparam logic [STATE_W-1:0] ST_TW  = 5'd2;
    localparam logic [STATE_W-1:0] ST_T3  = 5'd3;
    localparam logic [STATE_W-1:0] ST_T4  = 5'd4;
    localparam logic [STATE_W-1:0] ST_T5  = 5'd5;
    localparam logic [STATE_W-1:0] ST_T6  = 5'd6;
    localparam logic [STATE_W-1:0] ST_R1  = 5'd7;
    localparam logic [STATE_W-1:0] ST_R2  = 5'd8;
    localparam logic [STATE_W-1:0] ST_RW  = 5'd9;
    localparam logic [STATE_W-1:0] ST_R3  = 5'd10;
    localparam logic [STATE_W-1:0] ST_E1  = 5'd11;
    localparam logic [STATE_W-1:0] ST_E2  = 5'd12;
    localparam logic [STATE_W-1:0] ST_D1  = 5'd13;
    localparam logic [STATE_W-1:0] ST_D2  = 5'd14;
    localparam logic [STATE_W-1:0] ST_D3  = 5'd15;
    localparam logic [STATE_W-1:0] ST_D4  = 5'd16;
    localparam logic [STATE_W-1:0] ST_D5  = 5'd17;
    localparam logic [STATE_W-1:0] ST_D6  = 5'd18;
    localparam logic [STATE_W-1:0] ST_HLT = 5'd19;

    // Opcodes followed by one immediate byte: MVI r (00ddd110) and the
    // ALU-immediate group (11xxx110).
    function automatic logic is_imm_opc(input logic [7:0] opc);
        return ((opc[7:6] == 2'b00) || (opc[7:6] == 2'b11)) && (opc[2:0] == 3'b110);
    endfunction

endpackage

// File: rtl/core_ctrl_pcount.sv
// ----------------------------------------------------------------------------
// pcount
//   Free-running up counter with synchronous reset and increment enable.
//   Wraps silently at all-ones. Used for the PC; also suits an SP.
//   Ports:
//     i_clk  in   rising-edge clock
//     i_rst  in   synchronous active-high reset (count -> 0)
//     i_inc  in   increment enable
//     o_cnt  out  current count
// ----------------------------------------------------------------------------
module pcount #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + WIDTH'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_ctrl.sv
// ----------------------------------------------------------------------------
// core_ctrl
//   Machine-cycle sequencer for the 8085-style core. Runs the opcode fetch
//   (T1..T4 with TW waits), the optional immediate read (R1..R3 with RW
//   waits), the GO6 extension (T5/T6), the DAD stall (D1..D6) and the
//   two-state execute (E1/E2), and halts on HLT until reset.
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-high reset
//     bus_data  in   memory read data, snooped in T3 for the opcode
//     bus_rdy   in   memory ready, only looked at in T2/TW/R2/RW
//     chk_inst  in   datapath decode flags, only looked at in T4
//     bus_addr  out  memory address (PC during T1-T3/R1-R3, else held)
//     bus_ale   out  address latch enable (T1, R1)
//     bus_rd    out  read strobe
//     enb_code  out  load opcode register (T3)
//     enb_data  out  load operand register (R3)
//     enb_rreg  out  register-file read (E1)
//     enb_wreg  out  register-file write (E2)
//     stat_m1   out  opcode-fetch cycle indicator (T1-T4)
//     halted    out  HLT executed
// ----------------------------------------------------------------------------
module core_ctrl
    import core_defs::*;
#(
    parameter int DATASIZE = core_defs::DATASIZE,
    parameter int ADDRSIZE = core_defs::ADDRSIZE,
    parameter int INSTSIZE = core_defs::INSTSIZE,
    parameter int INST_GO6 = core_defs::INST_GO6,
    parameter int INST_DAD = core_defs::INST_DAD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] bus_data,
    input  logic                bus_rdy,
    input  logic [INSTSIZE-1:0] chk_inst,
    output logic [ADDRSIZE-1:0] bus_addr,
    output logic                bus_ale,
    output logic                bus_rd,
    output logic                enb_code,
    output logic                enb_data,
    output logic                enb_rreg,
    output logic                enb_wreg,
    output logic                stat_m1,
    output logic                halted
);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next;
    logic [DATASIZE-1:0] r_opc;
    logic [ADDRSIZE-1:0] r_addr_hold;
    logic [ADDRSIZE-1:0] w_pc;
    logic                w_pc_inc;
    logic                w_addr_phase;

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    pcount #(
        .WIDTH (ADDRSIZE)
    ) u_pc (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_pc_inc),
        .o_cnt (w_pc)
    );

    // PC advances at the end of each byte read (T3 for the opcode, R3 for
    // the immediate). A reset in the middle of a read never advances it
    // because pcount gives reset priority.
    assign w_pc_inc = (r_state == ST_T3) || (r_state == ST_R3);

    // ------------------------------------------------------------------
    // State register and opcode snoop
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_T1;
            r_opc   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_T3)
                r_opc <= bus_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = ST_T1;
        unique case (r_state)
            ST_T1:  w_next = ST_T2;
            ST_T2:  w_next = bus_rdy ? ST_T3 : ST_TW;
            ST_TW:  w_next = bus_rdy ? ST_T3 : ST_TW;
            ST_T3:  w_next = ST_T4;
            ST_T4: begin
                // Decode priority: HLT, GO6, immediate, DAD, plain.
                if (r_opc == DATASIZE'(OPC_HLT))
                    w_next = ST_HLT;
                else if (chk_inst[INST_GO6])
                    w_next = ST_T5;
                else if (is_imm_opc(r_opc))
                    w_next = ST_R1;
                else if (chk_inst[INST_DAD])
                    w_next = ST_D1;
                else
                    w_next = ST_E1;
            end
            ST_T5:  w_next = ST_T6;
            ST_T6:  w_next = ST_E1;
            ST_R1:  w_next = ST_R2;
            ST_R2:  w_next = bus_rdy ? ST_R3 : ST_RW;
            ST_RW:  w_next = bus_rdy ? ST_R3 : ST_RW;
            ST_R3:  w_next = ST_E1;
            ST_E1:  w_next = ST_E2;
            ST_E2:  w_next = ST_T1;
            ST_D1:  w_next = ST_D2;
            ST_D2:  w_next = ST_D3;
            ST_D3:  w_next = ST_D4;
            ST_D4:  w_next = ST_D5;
            ST_D5:  w_next = ST_D6;
            ST_D6:  w_next = ST_E1;
            ST_HLT: w_next = ST_HLT;
            default: w_next = ST_T1;
        endcase
    end

    // ------------------------------------------------------------------
    // Address bus: PC while a bus cycle is addressing memory, otherwise
    // the last driven address so the bus does not toggle between cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_phase = 1'b0;
        unique case (r_state)
            ST_T1, ST_T2, ST_TW, ST_T3,
            ST_R1, ST_R2, ST_RW, ST_R3: w_addr_phase = 1'b1;
            default:                    w_addr_phase = 1'b0;
        endcase
    end

    assign bus_addr = w_addr_phase ? w_pc : r_addr_hold;

    always_ff @(posedge clk) begin
        if (rst)
            r_addr_hold <= '0;
        else
            r_addr_hold <= bus_addr;
    end

    // ------------------------------------------------------------------
    // Strobes, decoded from state. They are masked by rst so that, while
    // reset is held, the bus and datapath see an idle controller rather
    // than the T1 it is parked in.
    // ------------------------------------------------------------------
    always_comb begin
        bus_ale  = 1'b0;
        bus_rd   = 1'b0;
        enb_code = 1'b0;
        enb_data = 1'b0;
        enb_rreg = 1'b0;
        enb_wreg = 1'b0;
        stat_m1  = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                ST_T1: begin
                    bus_ale = 1'b1;
                    stat_m1 = 1'b1;
                end
                ST_T2, ST_TW: begin
                    bus_rd  = 1'b1;
                    stat_m1 = 1'b1;
                end
                ST_T3: begin
                    bus_rd   = 1'b1;
                    enb_code = 1'b1;
                    stat_m1  = 1'b1;
                end
                ST_T4:  stat_m1 = 1'b1;
                ST_R1:  bus_ale = 1'b1;
                ST_R2, ST_RW: bus_rd = 1'b1;
                ST_R3: begin
                    bus_rd   = 1'b1;
                    enb_data = 1'b1;
                end
                ST_E1:  enb_rreg = 1'b1;
                ST_E2:  enb_wreg = 1'b1;
                ST_HLT: halted   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;
    import core_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus_data;
    logic        bus_rdy = 1'b1;
    logic [1:0]  chk_inst = 2'b00;
    logic [15:0] bus_addr;
    logic        bus_ale, bus_rd, enb_code, enb_data, enb_rreg, enb_wreg, stat_m1, halted;

    logic [7:0] mem [0:255];
    assign bus_data = mem[bus_addr[7:0]];

    core_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus_data (bus_data),
        .bus_rdy  (bus_rdy),
        .chk_inst (chk_inst),
        .bus_addr (bus_addr),
        .bus_ale  (bus_ale),
        .bus_rd   (bus_rd),
        .enb_code (enb_code),
        .enb_data (enb_data),
        .enb_rreg (enb_rreg),
        .enb_wreg (enb_wreg),
        .stat_m1  (stat_m1),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Observation record: flag byte {ale,rd,code,data,rreg,wreg,m1,hlt} + address
    typedef struct packed {
        logic [7:0]  f;
        logic [15:0] addr;
    } obs_t;

    localparam logic [7:0] F_ALE  = 8'h80;
    localparam logic [7:0] F_RD   = 8'h40;
    localparam logic [7:0] F_CODE = 8'h20;
    localparam logic [7:0] F_DATA = 8'h10;
    localparam logic [7:0] F_RREG = 8'h08;
    localparam logic [7:0] F_WREG = 8'h04;
    localparam logic [7:0] F_M1   = 8'h02;
    localparam logic [7:0] F_HLT  = 8'h01;

    int errors = 0;
    int checks = 0;

    // DUT-side cycle measurement: clocks between opcode-fetch T1 cycles
    int cyc = 0;
    int last_t1 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_ale && stat_m1) last_t1 <= cyc;
    end

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    bit          m_halt;

    function automatic obs_t mk(input logic [7:0] f, input logic [15:0] a);
        obs_t o;
        o.f = f;
        o.addr = a;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.f = {bus_ale, bus_rd, enb_code, enb_data, enb_rreg, enb_wreg, stat_m1, halted};
        o.addr = bus_addr;
        return o;
    endfunction

    // Opcodes carrying an immediate byte: low three bits 110, top two bits 00 or 11
    function automatic bit has_imm_byte(input logic [7:0] op);
        return (op[2:0] == 3'b110) && (op[7:6] != 2'b01) && (op[7:6] != 2'b10);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] rc();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = dut_obs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t flags got=%b want=%b addr got=%h want=%h",
                     name, $time, act.f, exp.f, act.addr, exp.addr);
        end
    endtask

    // Called at a negedge: check the current cycle, drive inputs for the
    // edge that ends it, advance to the next negedge.
    task automatic step(input string name, input obs_t exp, input logic rdy, input logic [1:0] chk);
        check_obs(name, exp);
        bus_rdy  = rdy;
        chk_inst = chk;
        @(negedge clk);
    endtask

    // One instruction, expected trace built from the bus-cycle rules.
    task automatic do_instr(input logic [1:0] chk, input int wf, input int wi);
        logic [7:0] op;
        op = mem[m_pc[7:0]];
        m_addr = m_pc;
        step("T1", mk(F_ALE | F_M1, m_addr), rb(), rc());
        for (int w = 0; w <= wf; w++)
            step("T2/TW", mk(F_RD | F_M1, m_addr), (w == wf), rc());
        step("T3", mk(F_RD | F_CODE | F_M1, m_addr), rb(), rc());
        m_pc = m_pc + 16'd1;
        step("T4", mk(F_M1, m_addr), rb(), chk);
        if (op == 8'h76) begin
            m_halt = 1'b1;
            return;
        end
        if (chk[0]) begin
            repeat (2) step("T5/T6", mk(8'h00, m_addr), rb(), rc());
        end else if (has_imm_byte(op)) begin
            m_addr = m_pc;
            step("R1", mk(F_ALE, m_addr), rb(), rc());
            for (int w = 0; w <= wi; w++)
                step("R2/RW", mk(F_RD, m_addr), (w == wi), rc());
            step("R3", mk(F_RD | F_DATA, m_addr), rb(), rc());
            m_pc = m_pc + 16'd1;
        end else if (chk[1]) begin
            repeat (6) step("D1-D6", mk(8'h00, m_addr), rb(), rc());
        end
        step("E1", mk(F_RREG, m_addr), rb(), rc());
        step("E2", mk(F_WREG, m_addr), rb(), rc());
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  imm;
        bit          has_imm;
        logic [1:0]  chk;
        int          wf;
        int          wi;
        int          cycles;
        logic [15:0] pc_after;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int a;
        int len;
        // {op, imm, has_imm, chk, fetch waits, imm waits, clocks, pc at next T1}
        tbl[0] = '{8'h80, 8'h00, 1'b0, 2'b00, 0, 0,  6, 16'h0001}; // ADD B
        tbl[1] = '{8'h3E, 8'h5A, 1'b1, 2'b00, 0, 0,  9, 16'h0003}; // MVI A
        tbl[2] = '{8'h09, 8'h00, 1'b0, 2'b10, 0, 0, 12, 16'h0004}; // DAD B
        tbl[3] = '{8'h00, 8'h00, 1'b0, 2'b01, 0, 0,  8, 16'h0005}; // GO6
        tbl[4] = '{8'h80, 8'h00, 1'b0, 2'b00, 3, 0,  9, 16'h0006}; // 3 fetch waits
        tbl[5] = '{8'h06, 8'hA5, 1'b1, 2'b00, 0, 2, 11, 16'h0008}; // MVI B, 2 waits
        tbl[6] = '{8'h3E, 8'h00, 1'b0, 2'b11, 0, 0,  8, 16'h0009}; // GO6 beats imm
        tbl[7] = '{8'h0E, 8'h11, 1'b1, 2'b10, 0, 0,  9, 16'h000B}; // imm beats DAD

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        a = 0;
        for (int i = 0; i < 8; i++) begin
            mem[a] = tbl[i].op;
            a++;
            if (tbl[i].has_imm) begin
                mem[a] = tbl[i].imm;
                a++;
            end
        end
        mem[a] = 8'h76; // HLT after the table

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_obs("reset", mk(8'h00, 16'h0000));
        rst = 1'b0;
        #1;
        m_pc = 16'h0000;
        m_addr = 16'h0000;
        m_halt = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_instr(tbl[i].chk, tbl[i].wf, tbl[i].wi);
            len = cyc - last_t1;
            checks++;
            if (len != tbl[i].cycles) begin
                errors++;
                $display("FAIL len[%0d] got=%0d want=%0d", i, len, tbl[i].cycles);
            end
            checks++;
            if (bus_addr !== tbl[i].pc_after || bus_ale !== 1'b1) begin
                errors++;
                $display("FAIL next_t1[%0d] addr got=%h want=%h ale=%b", i, bus_addr, tbl[i].pc_after, bus_ale);
            end
        end

        // HLT: stays halted with no bus activity, then rst recovers
        do_instr(2'b00, 0, 0);
        repeat (4) step("HLT", mk(F_HLT, m_addr), rb(), rc());
        rst = 1'b1;
        @(negedge clk);
        check_obs("rst_from_hlt", mk(8'h00, 16'h0000));
        rst = 1'b0;
        #1;
        m_pc = 16'h0000;
        m_halt = 1'b0;
        do_instr(2'b00, 0, 0); // mem[0]=ADD B from pc 0

        // Reset in the middle of a fetch wait state
        m_addr = m_pc;
        step("T1_abort", mk(F_ALE | F_M1, m_addr), 1'b0, 2'b00);
        step("T2_abort", mk(F_RD | F_M1, m_addr), 1'b0, 2'b00);
        step("TW_abort", mk(F_RD | F_M1, m_addr), 1'b0, 2'b00);
        check_obs("TW_before_rst", mk(F_RD | F_M1, 16'h0001));
        rst = 1'b1;
        @(negedge clk);
        check_obs("rst_from_tw", mk(8'h00, 16'h0000));
        rst = 1'b0;
        #1;
        m_pc = 16'h0000;
        do_instr(2'b00, 0, 0);

        // Randomized instruction stream against the model
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            mem[i] = (v == 8'h76) ? 8'h80 : v;
        end
        rst = 1'b1;
        @(negedge clk);
        check_obs("rst_random", mk(8'h00, 16'h0000));
        rst = 1'b0;
        #1;
        m_pc = 16'h0000;
        for (int i = 0; i < 250; i++)
            do_instr(rc(), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
